// File: rtl/player_position_stepper.sv
// player_position_stepper: moves one player's (x, y) cell one step per game
// tick in the filtered heading, raises a plot request for each new cell and
// freezes the player on a screen-border crash.
// Optional build macro PLAYER_WRAP_EN: borders wrap around instead of crashing.
module player_position_stepper #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int X_START     = 80,
  parameter int Y_START     = 20,
  parameter int TICK_CYCLES = 833333
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           restart,
  input  logic [1:0]     direction,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           plot_req,
  input  logic           plot_ack,
  output logic           crashed,
  output logic           overrun
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b11;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PLOT    = 2'b10,
    CRASHED = 2'b11
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [X_W-1:0]   x_r, x_s, mv_x_s;
  logic [Y_W-1:0]   y_r, y_s, mv_y_s;
  logic             req_r, req_s;
  logic             crash_r, crash_s;
  logic             ovr_r, ovr_s;
  logic             tick_s;
  logic             border_s;
  logic             hit_s;

  assign tick_s = enable && (cnt_r == CNT_LAST);

`ifdef PLAYER_WRAP_EN
  // Wrapping build: a border move never counts as a crash.
  assign hit_s = border_s & 1'b0;
`else
  assign hit_s = border_s;
`endif

  // Tick divider: advances only while the game runs, restart zeroes it.
  always_comb begin
    cnt_s = cnt_r;
    if (restart) begin
      cnt_s = '0;
    end else if (enable) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = '0;
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Candidate next cell; the border test comes before any add/subtract so the
  // arithmetic never leaves the legal range. Border hits yield the wrap cell.
  always_comb begin
    mv_x_s   = x_r;
    mv_y_s   = y_r;
    border_s = 1'b0;
    case (direction)
      DIR_UP: begin
        if (y_r == '0) begin
          border_s = 1'b1;
          mv_y_s   = Y_W'(Y_MAX);
        end else begin
          mv_y_s = y_r - Y_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (x_r == X_W'(X_MAX)) begin
          border_s = 1'b1;
          mv_x_s   = '0;
        end else begin
          mv_x_s = x_r + X_W'(1);
        end
      end
      DIR_DOWN: begin
        if (y_r == Y_W'(Y_MAX)) begin
          border_s = 1'b1;
          mv_y_s   = '0;
        end else begin
          mv_y_s = y_r + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (x_r == '0) begin
          border_s = 1'b1;
          mv_x_s   = X_W'(X_MAX);
        end else begin
          mv_x_s = x_r - X_W'(1);
        end
      end
      default: begin
        border_s = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic; restart overrides tick and ack.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    req_s   = req_r;
    crash_s = crash_r;
    ovr_s   = ovr_r;
    if (restart) begin
      state_s = IDLE;
      x_s     = X_W'(X_START);
      y_s     = Y_W'(Y_START);
      req_s   = 1'b0;
      crash_s = 1'b0;
      ovr_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Start cell is requested as soon as the game runs; the request is
          // then held in PLOT until the drawer accepts it.
          if (enable) begin
            state_s = PLOT;
            req_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (tick_s) begin
            if (hit_s) begin
              state_s = CRASHED;
              crash_s = 1'b1;
            end else begin
              state_s = PLOT;
              x_s     = mv_x_s;
              y_s     = mv_y_s;
              req_s   = 1'b1;
            end
          end else begin
            state_s = RUN;
          end
        end
        PLOT: begin
          if (tick_s) begin
            ovr_s = 1'b1;
          end else begin
            ovr_s = ovr_r;
          end
          if (plot_ack) begin
            state_s = RUN;
            req_s   = 1'b0;
          end else begin
            state_s = PLOT;
          end
        end
        CRASHED: begin
          state_s = CRASHED;
        end
        default: begin
          state_s = IDLE;
          req_s   = 1'b0;
        end
      endcase
    end
  end

  // State, position, flags and tick counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      x_r     <= X_W'(X_START);
      y_r     <= Y_W'(Y_START);
      req_r   <= 1'b0;
      crash_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      x_r     <= x_s;
      y_r     <= y_s;
      req_r   <= req_s;
      crash_r <= crash_s;
      ovr_r   <= ovr_s;
    end
  end

  assign x_out    = x_r;
  assign y_out    = y_r;
  assign plot_req = req_r;
  assign crashed  = crash_r;
  assign overrun  = ovr_r;

endmodule

// File: tb/tb_player_position_stepper.sv
// Testbench for player_position_stepper: two instances (start x 80 and 1),
// directed scenarios followed by random stimulus, every cycle compared with
// a behavioural model of the movement rules.
module tb_player_position_stepper;

  localparam int TC    = 4;
  localparam int XMAX  = 159;
  localparam int YMAX  = 119;
  localparam int YS    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable    [2];
  logic       restart   [2];
  logic       plot_ack  [2];
  logic [1:0] direction [2];
  logic [7:0] x_out     [2];
  logic [6:0] y_out     [2];
  logic       plot_req  [2];
  logic       crashed   [2];
  logic       overrun   [2];
  bit         auto_ack  [2];

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;
  bit prev_req0  = 1'b0;

  // model state
  int XS [2] = '{80, 1};
  int mx [2], my [2], mcnt [2];
  bit mstart [2], mpend [2], mcrash [2], movr [2];

  always #5 clk = ~clk;

  player_position_stepper #(.TICK_CYCLES(TC)) dut_a (
    .clk(clk), .reset(reset), .enable(enable[0]), .restart(restart[0]),
    .direction(direction[0]), .x_out(x_out[0]), .y_out(y_out[0]),
    .plot_req(plot_req[0]), .plot_ack(plot_ack[0]), .crashed(crashed[0]),
    .overrun(overrun[0])
  );

  player_position_stepper #(.TICK_CYCLES(TC), .X_START(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable[1]), .restart(restart[1]),
    .direction(direction[1]), .x_out(x_out[1]), .y_out(y_out[1]),
    .plot_req(plot_req[1]), .plot_ack(plot_ack[1]), .crashed(crashed[1]),
    .overrun(overrun[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_init(input int i);
    mx[i] = XS[i]; my[i] = YS; mcnt[i] = 0;
    mstart[i] = 1'b0; mpend[i] = 1'b0; mcrash[i] = 1'b0; movr[i] = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs present at that edge.
  task automatic model_cycle(input int i);
    bit tick;
    int nx, ny;
    if (restart[i]) begin
      model_init(i);
    end else begin
      tick = enable[i] && (mcnt[i] == TC - 1);
      if (enable[i]) mcnt[i] = (mcnt[i] + 1) % TC;
      if (!mstart[i]) begin
        if (enable[i]) begin
          mstart[i] = 1'b1;
          mpend[i]  = 1'b1;
        end
      end else if (mcrash[i]) begin
        mpend[i] = 1'b0;
      end else if (mpend[i]) begin
        if (tick) movr[i] = 1'b1;
        if (plot_ack[i]) mpend[i] = 1'b0;
      end else if (tick) begin
        nx = mx[i];
        ny = my[i];
        case (direction[i])
          2'b00:   ny = ny - 1;
          2'b01:   nx = nx + 1;
          2'b11:   ny = ny + 1;
          default: nx = nx - 1;
        endcase
        if (nx < 0 || nx > XMAX || ny < 0 || ny > YMAX) begin
`ifdef PLAYER_WRAP_EN
          mx[i] = (nx + XMAX + 1) % (XMAX + 1);
          my[i] = (ny + YMAX + 1) % (YMAX + 1);
          mpend[i] = 1'b1;
`else
          mcrash[i] = 1'b1;
`endif
        end else begin
          mx[i] = nx;
          my[i] = ny;
          mpend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_cycle(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m%0d.x", i), 32'(x_out[i]), 32'(mx[i]));
      check($sformatf("m%0d.y", i), 32'(y_out[i]), 32'(my[i]));
      check($sformatf("m%0d.req", i), 32'(plot_req[i]), 32'(mpend[i]));
      check($sformatf("m%0d.crash", i), 32'(crashed[i]), 32'(mcrash[i]));
      check($sformatf("m%0d.ovr", i), 32'(overrun[i]), 32'(movr[i]));
      if (auto_ack[i]) plot_ack[i] = plot_req[i];
    end
    if (plot_req[0] && !prev_req0) pulses++;
    prev_req0 = plot_req[0];
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b0; restart[i] = 1'b0; plot_ack[i] = 1'b0;
      direction[i] = 2'b00; auto_ack[i] = 1'b0;
      model_init(i);
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst.x", 32'(x_out[0]), 32'd80);
    check("rst.y", 32'(y_out[0]), 32'd20);
    check("rst.req", 32'(plot_req[0]), 32'd0);
    check("rst.crash", 32'(crashed[0]), 32'd0);
    check("rst.ovr", 32'(overrun[0]), 32'd0);
    check("rst.bx", 32'(x_out[1]), 32'd1);
    reset = 1'b0;
    step();

    // Start cell, then three right moves (a) and left moves toward x=0 (b).
    enable[0] = 1'b1; direction[0] = 2'b01; auto_ack[0] = 1'b1;
    enable[1] = 1'b1; direction[1] = 2'b10; auto_ack[1] = 1'b1;
    step();
    check("start.req", 32'(plot_req[0]), 32'd1);
    check("start.x", 32'(x_out[0]), 32'd80);
    check("start.y", 32'(y_out[0]), 32'd20);
    repeat (7) step();
`ifdef PLAYER_WRAP_EN
    check("wrap.x", 32'(x_out[1]), 32'd159);
    check("wrap.req", 32'(plot_req[1]), 32'd1);
    check("wrap.crash", 32'(crashed[1]), 32'd0);
`else
    check("crash.x", 32'(x_out[1]), 32'd0);
    check("crash.flag", 32'(crashed[1]), 32'd1);
    check("crash.req", 32'(plot_req[1]), 32'd0);
`endif
    repeat (4) step();
    check("right.x", 32'(x_out[0]), 32'd83);
    check("right.y", 32'(y_out[0]), 32'd20);
    check("right.ovr", 32'(overrun[0]), 32'd0);
    check("right.pulses", 32'(pulses), 32'd4);
`ifndef PLAYER_WRAP_EN
    check("frozen.req", 32'(plot_req[1]), 32'd0);
    check("frozen.x", 32'(x_out[1]), 32'd0);
`endif

    // Ack the last move on a; restart b.
    restart[1] = 1'b1;
    step();
    restart[1] = 1'b0; direction[1] = 2'b01;
    check("restart.bx", 32'(x_out[1]), 32'd1);
    check("restart.bcrash", 32'(crashed[1]), 32'd0);
    check("restart.breq", 32'(plot_req[1]), 32'd0);

    // Down with ack withheld: one move, then a dropped tick.
    auto_ack[0] = 1'b0; plot_ack[0] = 1'b0; direction[0] = 2'b11;
    repeat (10) step();
    check("hold.y", 32'(y_out[0]), 32'd21);
    check("hold.x", 32'(x_out[0]), 32'd83);
    check("hold.req", 32'(plot_req[0]), 32'd1);
    check("hold.ovr", 32'(overrun[0]), 32'd1);
    plot_ack[0] = 1'b1;
    step();
    plot_ack[0] = 1'b0;
    check("ack.req", 32'(plot_req[0]), 32'd0);
    repeat (4) step();
    check("down2.y", 32'(y_out[0]), 32'd22);
    check("down2.req", 32'(plot_req[0]), 32'd1);

    // Restart together with ack and tick.
    repeat (3) step();
    plot_ack[0] = 1'b1; restart[0] = 1'b1;
    step();
    plot_ack[0] = 1'b0; restart[0] = 1'b0;
    check("rsack.x", 32'(x_out[0]), 32'd80);
    check("rsack.y", 32'(y_out[0]), 32'd20);
    check("rsack.req", 32'(plot_req[0]), 32'd0);
    check("rsack.ovr", 32'(overrun[0]), 32'd0);

    // Random play against the model.
    auto_ack[0] = 1'b0; auto_ack[1] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        enable[i]    = ($urandom_range(0, 9) != 0);
        restart[i]   = ($urandom_range(0, 79) == 0);
        plot_ack[i]  = plot_req[i] && ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) direction[i] = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
